// File: rtl/traffic_intersection_model.sv
// rtl/traffic_intersection_model.sv - two-street queue model and light-sequence monitor
// Optional feature macro: TRAFFIC_MODEL_STATS_EN (saturating violation counter on viol_cnt).
module traffic_intersection_model (
  input  logic       clk,
  input  logic       reset,
  input  logic       arrive_a,
  input  logic       arrive_b,
  input  logic       la_g,
  input  logic       la_y,
  input  logic       lb_g,
  input  logic       lb_y,
  output logic       sens_a,
  output logic       sens_b,
  output logic [3:0] qlen_a,
  output logic [3:0] qlen_b,
  output logic       ovf_a,
  output logic       ovf_b,
  output logic       viol,
  output logic [2:0] viol_code,
  output logic       err,
  output logic       locked,
  output logic [7:0] viol_cnt
);

  typedef enum logic [2:0] {P_AG, P_AY, P_RED, P_BG, P_BY, P_ILL} phase_t;
  typedef enum logic [2:0] {M_AG, M_AY, M_R1, M_BG, M_BY, M_R2, M_SYNC} mstate_t;

  phase_t     phase;
  mstate_t    state, state_nxt;
  logic [2:0] red_cnt, red_nxt;
  logic       viol_nxt;
  logic [2:0] code_nxt;
  logic       sens_a_q, sens_b_q;

  assign sens_a = (qlen_a != 4'd0);
  assign sens_b = (qlen_b != 4'd0);
  assign locked = (state != M_SYNC);

  // Decode the four observed lamps into a phase; anything else is illegal.
  always_comb begin
    phase = P_ILL;
    case ({la_g, la_y, lb_g, lb_y})
      4'b1000: phase = P_AG;
      4'b0100: phase = P_AY;
      4'b0000: phase = P_RED;
      4'b0010: phase = P_BG;
      4'b0001: phase = P_BY;
      default: phase = P_ILL;
    endcase
  end

  // Street A queue: a car arriving on green passes straight through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qlen_a <= 4'd0;
      ovf_a  <= 1'b0;
    end else if (arrive_a && !la_g) begin
      if (qlen_a == 4'd15) ovf_a <= 1'b1;
      else                 qlen_a <= qlen_a + 4'd1;
    end else if (!arrive_a && la_g && qlen_a != 4'd0) begin
      qlen_a <= qlen_a - 4'd1;
    end
  end

  // Street B queue, same rules as street A.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qlen_b <= 4'd0;
      ovf_b  <= 1'b0;
    end else if (arrive_b && !lb_g) begin
      if (qlen_b == 4'd15) ovf_b <= 1'b1;
      else                 qlen_b <= qlen_b + 4'd1;
    end else if (!arrive_b && lb_g && qlen_b != 4'd0) begin
      qlen_b <= qlen_b - 4'd1;
    end
  end

  // Monitor next state: check the current sample against the previous phase.
  always_comb begin
    state_nxt = state;
    red_nxt   = red_cnt;
    viol_nxt  = 1'b0;
    code_nxt  = 3'd0;
    if (state == M_SYNC) begin
      red_nxt = 3'd0;
      if (phase == P_AG) state_nxt = M_AG;
    end else if (phase == P_ILL) begin
      viol_nxt = 1'b1; code_nxt = 3'd1;
    end else begin
      case (state)
        M_AG: begin
          if (phase == P_AY) begin
            if (sens_a_q) begin viol_nxt = 1'b1; code_nxt = 3'd5; end
            else state_nxt = M_AY;
          end else if (phase != P_AG) begin
            viol_nxt = 1'b1; code_nxt = 3'd2;
          end
        end
        M_BG: begin
          if (phase == P_BY) begin
            if (sens_b_q) begin viol_nxt = 1'b1; code_nxt = 3'd5; end
            else state_nxt = M_BY;
          end else if (phase != P_BG) begin
            viol_nxt = 1'b1; code_nxt = 3'd2;
          end
        end
        M_AY, M_BY: begin
          if (phase == P_RED) begin
            state_nxt = (state == M_AY) ? M_R1 : M_R2;
            red_nxt   = 3'd1;
          end else if ((state == M_AY && phase == P_AY) || (state == M_BY && phase == P_BY)) begin
            viol_nxt = 1'b1; code_nxt = 3'd3;
          end else begin
            viol_nxt = 1'b1; code_nxt = 3'd2;
          end
        end
        M_R1, M_R2: begin
          if (phase == P_RED) begin
            if (red_cnt == 3'd6) begin viol_nxt = 1'b1; code_nxt = 3'd4; end
            else red_nxt = red_cnt + 3'd1;
          end else if ((state == M_R1 && phase == P_BG) || (state == M_R2 && phase == P_AG)) begin
            if (red_cnt == 3'd6) begin
              state_nxt = (state == M_R1) ? M_BG : M_AG;
              red_nxt   = 3'd0;
            end else begin
              viol_nxt = 1'b1; code_nxt = 3'd4;
            end
          end else begin
            viol_nxt = 1'b1; code_nxt = 3'd2;
          end
        end
        default: state_nxt = M_SYNC;
      endcase
    end
    if (viol_nxt) begin
      state_nxt = M_SYNC;
      red_nxt   = 3'd0;
    end
  end

  // Monitor registers: state, red run length, registered violation report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= M_AG;
      red_cnt   <= 3'd0;
      viol      <= 1'b0;
      viol_code <= 3'd0;
      err       <= 1'b0;
      sens_a_q  <= 1'b0;
      sens_b_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      red_cnt   <= red_nxt;
      viol      <= viol_nxt;
      viol_code <= code_nxt;
      sens_a_q  <= sens_a;
      sens_b_q  <= sens_b;
      if (viol_nxt) err <= 1'b1;
    end
  end

`ifdef TRAFFIC_MODEL_STATS_EN
  // Saturating count of violation pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              viol_cnt <= 8'd0;
    else if (viol_nxt && viol_cnt != 8'hFF) viol_cnt <= viol_cnt + 8'd1;
  end
`else
  assign viol_cnt = 8'd0;
`endif

endmodule
